// File: rtl/single_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : single_arb_mux
//  Purpose  : Registered NUM_CH-to-1 multiplexer with round-robin arbitration
//             and valid/ready handshaking on every input and on the output.
//             The selected word sits in a one-entry output register until
//             the consumer accepts it; a new word may replace it in the same
//             cycle it is consumed, giving one transfer per cycle.
//  Ports    : clk, rst (async, active high)
//             in_data   [NUM_CH*WIDTH] packed channel words, ch i at i*WIDTH
//             in_valid  [NUM_CH]       per-channel request
//             in_ready  [NUM_CH]       per-channel accept (one-hot or zero)
//             out_data  [WIDTH]        registered selected word
//             out_sel   [SEL_W]        channel that supplied out_data
//             out_valid                out_data holds an unconsumed word
//             out_ready                consumer takes out_data this cycle
//             xfer_cnt  [16]           wrapping count of output handshakes
//  Option   : SINGLE_ARB_MUX_FORCE_EN adds force_en / force_sel, which
//             override the round-robin choice without disturbing its order.
//  Revision : 1.0  initial release
// ============================================================================
module single_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_cnt
`ifdef SINGLE_ARB_MUX_FORCE_EN
    ,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel
`endif
);

    localparam logic [SEL_W-1:0] c_LAST_RST = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;
    logic [15:0]      r_xfer_cnt;
    logic [SEL_W-1:0] r_last_grant;

    logic             w_slot_free;
    logic             w_found;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_scan_idx;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_grant_data;
`ifdef SINGLE_ARB_MUX_FORCE_EN
    logic             w_forced;
`endif

    // The register can take a new word when empty or when it is being
    // drained in this very cycle.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_out_hs    = r_out_valid && out_ready;
    assign w_in_hs     = w_found && w_slot_free;

    // Round-robin scan: offsets 1..NUM_CH from the last grant, so the last
    // granted channel is considered only after every other one.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_scan_idx = SEL_W'((int'(r_last_grant) + k) % NUM_CH);
            if (!w_found && in_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_grant = w_scan_idx;
            end
        end
`ifdef SINGLE_ARB_MUX_FORCE_EN
        w_forced = 1'b0;
        if (force_en) begin
            w_forced = 1'b1;
            w_grant  = force_sel;
            w_found  = (int'(force_sel) < NUM_CH) && in_valid[force_sel];
        end
`endif
    end

    // Data select feeds only the output register, never an output port.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
            assign in_ready[i] = w_in_hs && (w_grant == SEL_W'(i));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_out_valid  <= 1'b0;
            r_xfer_cnt   <= '0;
            r_last_grant <= c_LAST_RST;
        end else begin
            if (w_in_hs) begin
                r_out_data  <= w_grant_data;
                r_out_sel   <= w_grant;
                r_out_valid <= 1'b1;
`ifdef SINGLE_ARB_MUX_FORCE_EN
                // Forced grants leave the rotation pointer where it was.
                if (!w_forced) begin
                    r_last_grant <= w_grant;
                end
`else
                r_last_grant <= w_grant;
`endif
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_single_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_single_arb_mux
//  Purpose  : Self-checking bench for single_arb_mux: a transaction-level
//             model checked every cycle, plus hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_single_arb_mux;

    localparam int W     = 32;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      xfer_cnt;
`ifdef SINGLE_ARB_MUX_FORCE_EN
    logic             force_en;
    logic [SEL_W-1:0] force_sel;
`endif

    int n_total;
    int n_bad;

    single_arb_mux #(.WIDTH(W), .NUM_CH(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
`ifdef SINGLE_ARB_MUX_FORCE_EN
        ,
        .force_en  (force_en),
        .force_sel (force_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The chosen requester is the valid channel with the smallest circular
    // distance past the previously granted one.
    int             m_last;
    logic           m_valid;
    logic [W-1:0]   m_data;
    int             m_sel;
    logic [15:0]    m_cnt;
    int             m_grant;
    logic           m_in_hs;
    logic [N-1:0]   m_exp_ready;

    function automatic int model_grant(input logic [N-1:0] v, input int last);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
`ifdef SINGLE_ARB_MUX_FORCE_EN
        if (force_en) begin
            if (int'(force_sel) < N && v[force_sel]) return int'(force_sel);
            return -1;
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d;
                d = (i - last - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always_comb begin
        m_grant     = model_grant(in_valid, m_last);
        m_in_hs     = (m_grant >= 0) && (!m_valid || out_ready);
        m_exp_ready = '0;
        if (m_in_hs) m_exp_ready[m_grant] = 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last  <= N - 1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= 0;
            m_cnt   <= '0;
        end else begin
            if (m_in_hs) begin
                m_valid <= 1'b1;
                m_data  <= in_data[m_grant*W +: W];
                m_sel   <= m_grant;
`ifdef SINGLE_ARB_MUX_FORCE_EN
                if (!force_en) m_last <= m_grant;
`else
                m_last <= m_grant;
`endif
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && out_ready) m_cnt <= m_cnt + 16'd1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready",  32'(in_ready),  32'(m_exp_ready));
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_out_data",  out_data,       m_data);
            chk("m_out_sel",   32'(out_sel),   32'(m_sel));
            chk("m_xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] d);
        in_data[c*W +: W] = d;
    endtask

    logic [N-1:0] vec_valid [10] = '{4'b0110, 4'b0110, 4'b1111, 4'b0001, 4'b1000,
                                     4'b1010, 4'b0000, 4'b0101, 4'b1111, 4'b0000};
    logic         vec_ready [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef SINGLE_ARB_MUX_FORCE_EN
        force_en  = 1'b0;
        force_sel = '0;
`endif
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        tick;
        rst = 1'b0;

        // All channels valid, out_ready high: strict rotation 0,1,2,3,...
        for (int c = 0; c < N; c++) set_ch(c, 32'h10 + 32'(c));
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick;
            chk("rr_sel",  32'(out_sel), 32'(j % 4));
            chk("rr_data", out_data,     32'h10 + 32'(j % 4));
        end
        in_valid = '0;
        tick;
        chk("rr_cnt",   32'(xfer_cnt),  32'd8);
        chk("rr_drain", 32'(out_valid), 32'd0);

        // Wrap-around: last grant is 3, channels 0 and 3 request
        in_valid = 4'b1001;
        #1;
        chk("wrap_ready", 32'(in_ready), 32'b0001);
        tick;
        chk("wrap_sel",  32'(out_sel), 32'd0);
        chk("wrap_data", out_data,     32'h10);
        in_valid = '0;
        tick;
        chk("wrap_cnt", 32'(xfer_cnt), 32'd9);

        // Stall: single word from channel 2 held while consumer is not ready
        set_ch(2, 32'hABCD);
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        tick;
        set_ch(2, 32'h1234);
        for (int j = 0; j < 3; j++) begin
            chk("stall_data",  out_data,        32'hABCD);
            chk("stall_sel",   32'(out_sel),    32'd2);
            chk("stall_valid", 32'(out_valid),  32'd1);
            chk("stall_ready", 32'(in_ready),   32'd0);
            tick;
        end
        out_ready = 1'b1;
        in_valid  = '0;
        tick;
        chk("stall_empty", 32'(out_valid), 32'd0);
        chk("stall_cnt",   32'(xfer_cnt),  32'd10);

        // Mixed request/ready patterns, checked by the model
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < N; c++) set_ch(c, 32'h200 + 32'(c) + 32'(16 * j));
            in_valid  = vec_valid[j];
            out_ready = vec_ready[j];
            tick;
        end
        in_valid  = '0;
        out_ready = 1'b1;
        tick;

`ifdef SINGLE_ARB_MUX_FORCE_EN
        // Force: last grant 0, force channel 3 with 1 and 3 requesting
        in_valid = 4'b0001;
        tick;
        in_valid  = 4'b1010;
        force_en  = 1'b1;
        force_sel = 2'd3;
        #1;
        chk("force_ready", 32'(in_ready), 32'b1000);
        tick;
        chk("force_sel", 32'(out_sel), 32'd3);
        force_en = 1'b0;
        #1;
        chk("force_resume_ready", 32'(in_ready), 32'b0010);
        tick;
        chk("force_resume_sel", 32'(out_sel), 32'd1);
        in_valid = '0;
        tick;
`endif

        // Asynchronous reset while FULL
        set_ch(0, 32'hDEADBEEF);
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick;
        chk("full_data", out_data, 32'hDEADBEEF);
        in_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  out_data,       32'd0);
        chk("arst_cnt",   32'(xfer_cnt),  32'd0);
        chk("arst_sel",   32'(out_sel),   32'd0);
        tick;
        rst = 1'b0;

        // Counter wrap: 65535 edges of continuous traffic -> 65534 outputs
        for (int c = 0; c < N; c++) set_ch(c, 32'h300 + 32'(c));
        in_valid  = 4'hF;
        out_ready = 1'b1;
        repeat (65535) tick;
        chk("cnt_fffe", 32'(xfer_cnt), 32'h0000FFFE);
        tick;
        tick;
        chk("cnt_wrap", 32'(xfer_cnt), 32'h00000000);
        in_valid = '0;
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
